stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Stopwatch control and minutes/seconds BCD accumulator downstream of the 1-second prescaler/counter stage. It consumes that stage's one-cycle carry pulse (one per elapsed second) and drives the stage's `enable`. It runs a start/stop/clear state machine and produces four BCD digits (MM:SS, 00:00–59:59) for the display driver. An optional lap feature freezes the displayed time while counting continues.

## Interface
- `MAX_MIN_TENS`, default 5: highest minutes-tens digit before wrap. Legal range 1–9.
- `clk` input 1: system clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `btn_start_stop` input 1: one-cycle pulse (debounced upstream); toggles run/pause.
- `btn_clear` input 1: one-cycle pulse; return to zero.
- `btn_lap` input 1: one-cycle pulse; lap freeze/release (`STOPWATCH_LAP_EN` only).
- `tick_in` input 1: one-cycle pulse per elapsed second, from the upstream carry output.
- `count_en` output 1: registered enable to the upstream counter.
- `sub_clear` output 1: registered one-cycle pulse. The top level uses it to clear the upstream counter's sub-second state.
- `disp_sec_ones` output 4: displayed seconds ones, BCD 0–9.
- `disp_sec_tens` output 4: displayed seconds tens, BCD 0–5.
- `disp_min_ones` output 4: displayed minutes ones, BCD 0–9.
- `disp_min_tens` output 4: displayed minutes tens, BCD 0–MAX_MIN_TENS.
- `running` output 1: high in RUN.
- `ovf` output 1: sticky; set on wrap from max to 00:00.
- `lap_active` output 1: high while the display is frozen.

## Operation
- States:
  - IDLE: counts zero, `count_en`=0.
  - RUN: `count_en`=1.
  - PAUSE: `count_en`=0, counts held.
- Transitions:
  - IDLE → RUN on `btn_start_stop`.
  - RUN → PAUSE on `btn_start_stop`.
  - PAUSE → RUN on `btn_start_stop`.
  - Any state → IDLE on `btn_clear`.
- Button priority when pulses coincide: clear > start_stop > lap. Only the highest-priority pulse acts in that cycle; the others are dropped.
- Clear behaviour:
  - Zeroes all live digits, `ovf`, the lap freeze and the frozen digits.
  - Asserts `sub_clear` for exactly one cycle.
  - In IDLE it still pulses `sub_clear`.
- Counting:
  - `tick_in` is accepted in RUN, and in the same cycle as a RUN→PAUSE `btn_start_stop`, because the upstream enable drop is registered and that tick is real elapsed time.
  - `tick_in` is ignored in IDLE and PAUSE, and in any cycle where `btn_clear` is high.
- Digit cascade per accepted tick:
  - `sec_ones` 9→0 with carry into `sec_tens`.
  - `sec_tens` 5→0 with carry into `min_ones`.
  - `min_ones` 9→0 with carry into `min_tens`.
  - `min_tens` MAX_MIN_TENS→0.
- Wrap: a tick at MAX:59 (e.g. 59:59) → 00:00, `ovf`←1, state stays RUN.
- Each digit is a 4-bit register and never holds a value outside its BCD range.
- Display outputs equal the live digits unless `lap_active`=1, in which case they show the frozen copy.

## Timing
- Reset values:
  - State IDLE.
  - `count_en`, `sub_clear`, `running`, `ovf`, `lap_active` = 0.
  - All digits = 0.
- All outputs are registered; no combinational path from input to output.
- Button-to-state latency:
  - `btn_start_stop` in cycle N → `running`/`count_en` change at edge N+1.
  - `btn_clear` in cycle N → digits zero and `sub_clear`=1 from edge N+1, for one cycle only.
- Tick-to-display latency: `tick_in` in cycle N → incremented digits visible after edge N+1, and `ovf` set at the same edge as the wrap.
- Reset mid-operation: asynchronous return to the reset values. No `sub_clear` pulse, because the upstream block shares `resetn`.

## Configuration
- Macro `STOPWATCH_LAP_EN`.
- With `STOPWATCH_LAP_EN` defined:
  - `btn_lap` in RUN toggles the freeze: rising freeze copies the live digits (post-tick if a tick lands the same cycle) into the frozen registers and sets `lap_active`.
  - A second lap pulse in RUN releases the freeze, clearing `lap_active`.
  - In PAUSE, lap releases the freeze.
  - In IDLE, lap is ignored.
  - The live count continues throughout.
- Without `STOPWATCH_LAP_EN`:
  - `btn_lap` is ignored, `lap_active` is tied 0, and the display is always live.
  - No frozen registers are synthesised.

## Test plan
- Reset, start, then 75 ticks → display 01:15, `running`=1, `count_en`=1 one cycle after start.
- Start, 3 ticks, stop pulse coincident with the 4th tick → 00:04, PAUSE, `count_en`=0; 2 further ticks ignored → still 00:04.
- Preload to 59:59 (3599 ticks), 1 more tick → 00:00, `ovf`=1, still RUN; clear → `ovf`=0, IDLE, `sub_clear` high exactly one cycle.
- `btn_clear` and `btn_start_stop` in the same cycle from RUN at 00:10 → IDLE, 00:00; a tick in that cycle is not counted.
- `STOPWATCH_LAP_EN`: start, 10 ticks, lap → display frozen at 00:10, 5 more ticks → display 00:10, `lap_active`=1; lap again → display 00:15, `lap_active`=0.
- Async `resetn` low mid-RUN at 02:30 → all outputs 0 immediately; after release, tick pulses ignored until start.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: button pulses and tick in, enable/pulse/display out.
// The master modport is the side that drives buttons and ticks (top level or bench);
// the slave modport is the stopwatch_ctrl block itself.
interface stopwatch_ctrl_if;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       btn_lap;
    logic       tick_in;

    logic       count_en;
    logic       sub_clear;
    logic [3:0] disp_sec_ones;
    logic [3:0] disp_sec_tens;
    logic [3:0] disp_min_ones;
    logic [3:0] disp_min_tens;
    logic       running;
    logic       ovf;
    logic       lap_active;

    modport master (
        output btn_start_stop,
        output btn_clear,
        output btn_lap,
        output tick_in,
        input  count_en,
        input  sub_clear,
        input  disp_sec_ones,
        input  disp_sec_tens,
        input  disp_min_ones,
        input  disp_min_tens,
        input  running,
        input  ovf,
        input  lap_active
    );

    modport slave (
        input  btn_start_stop,
        input  btn_clear,
        input  btn_lap,
        input  tick_in,
        output count_en,
        output sub_clear,
        output disp_sec_ones,
        output disp_sec_tens,
        output disp_min_ones,
        output disp_min_tens,
        output running,
        output ovf,
        output lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/stop/clear controller with an MM:SS BCD accumulator.
// Consumes the one-second carry pulse from the upstream prescaler and drives its enable.
// Optional lap freeze is built only when the macro STOPWATCH_LAP_EN is defined;
// without it btn_lap is ignored, lap_active is 0 and the display is always live.
module stopwatch_ctrl #(
    parameter int MAX_MIN_TENS = 5
) (
    input  logic              clk,
    input  logic              resetn,
    stopwatch_ctrl_if.slave   sw
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN_TENS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e     state_q, state_d;

    logic       count_en_q, count_en_d;
    logic       running_q, running_d;
    logic       sub_clear_q, sub_clear_d;
    logic       ovf_q, ovf_d;

    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;

    logic       tick_ok;

    // A tick counts only in RUN (including the cycle RUN->PAUSE is requested) and never under clear
    assign tick_ok = sw.tick_in && !sw.btn_clear && (state_q == ST_RUN);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear wins over start/stop
    always_comb begin
        state_d = state_q;
        if (sw.btn_clear) begin
            state_d = ST_IDLE;
        end else if (sw.btn_start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state edge
    always_comb begin
        count_en_d  = (state_d == ST_RUN);
        running_d   = (state_d == ST_RUN);
        sub_clear_d = sw.btn_clear;
    end

    // BCD cascade and sticky overflow; clear zeroes everything
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        ovf_d      = ovf_q;
        if (sw.btn_clear) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
            ovf_d      = 1'b0;
        end else if (tick_ok) begin
            if (sec_ones_q < 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q < 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q < 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q < MAX_TENS) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
                            ovf_d      = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Registered outputs and live digits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_en_q  <= 1'b0;
            running_q   <= 1'b0;
            sub_clear_q <= 1'b0;
            ovf_q       <= 1'b0;
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            min_tens_q  <= 4'd0;
        end else begin
            count_en_q  <= count_en_d;
            running_q   <= running_d;
            sub_clear_q <= sub_clear_d;
            ovf_q       <= ovf_d;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
        end
    end

    assign sw.count_en  = count_en_q;
    assign sw.running   = running_q;
    assign sw.sub_clear = sub_clear_q;
    assign sw.ovf       = ovf_q;

`ifdef STOPWATCH_LAP_EN

    logic       lap_evt;
    logic       lap_active_q, lap_active_d;
    logic [3:0] frz_sec_ones_q, frz_sec_ones_d;
    logic [3:0] frz_sec_tens_q, frz_sec_tens_d;
    logic [3:0] frz_min_ones_q, frz_min_ones_d;
    logic [3:0] frz_min_tens_q, frz_min_tens_d;
    logic [3:0] disp_sec_ones_q, disp_sec_ones_d;
    logic [3:0] disp_sec_tens_q, disp_sec_tens_d;
    logic [3:0] disp_min_ones_q, disp_min_ones_d;
    logic [3:0] disp_min_tens_q, disp_min_tens_d;

    // Lap acts only when neither clear nor start/stop is pulsed in the same cycle
    assign lap_evt = sw.btn_lap && !sw.btn_clear && !sw.btn_start_stop;

    // Lap freeze: toggle in RUN capturing post-tick digits, release in PAUSE, ignore in IDLE
    always_comb begin
        lap_active_d   = lap_active_q;
        frz_sec_ones_d = frz_sec_ones_q;
        frz_sec_tens_d = frz_sec_tens_q;
        frz_min_ones_d = frz_min_ones_q;
        frz_min_tens_d = frz_min_tens_q;
        if (sw.btn_clear) begin
            lap_active_d   = 1'b0;
            frz_sec_ones_d = 4'd0;
            frz_sec_tens_d = 4'd0;
            frz_min_ones_d = 4'd0;
            frz_min_tens_d = 4'd0;
        end else if (lap_evt) begin
            if (state_q == ST_RUN) begin
                if (lap_active_q) begin
                    lap_active_d = 1'b0;
                end else begin
                    lap_active_d   = 1'b1;
                    frz_sec_ones_d = sec_ones_d;
                    frz_sec_tens_d = sec_tens_d;
                    frz_min_ones_d = min_ones_d;
                    frz_min_tens_d = min_tens_d;
                end
            end else if (state_q == ST_PAUSE) begin
                lap_active_d = 1'b0;
            end
        end
    end

    // Display source select, computed ahead so the display itself is a register
    always_comb begin
        disp_sec_ones_d = lap_active_d ? frz_sec_ones_d : sec_ones_d;
        disp_sec_tens_d = lap_active_d ? frz_sec_tens_d : sec_tens_d;
        disp_min_ones_d = lap_active_d ? frz_min_ones_d : min_ones_d;
        disp_min_tens_d = lap_active_d ? frz_min_tens_d : min_tens_d;
    end

    // Lap state, frozen copy and display registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lap_active_q    <= 1'b0;
            frz_sec_ones_q  <= 4'd0;
            frz_sec_tens_q  <= 4'd0;
            frz_min_ones_q  <= 4'd0;
            frz_min_tens_q  <= 4'd0;
            disp_sec_ones_q <= 4'd0;
            disp_sec_tens_q <= 4'd0;
            disp_min_ones_q <= 4'd0;
            disp_min_tens_q <= 4'd0;
        end else begin
            lap_active_q    <= lap_active_d;
            frz_sec_ones_q  <= frz_sec_ones_d;
            frz_sec_tens_q  <= frz_sec_tens_d;
            frz_min_ones_q  <= frz_min_ones_d;
            frz_min_tens_q  <= frz_min_tens_d;
            disp_sec_ones_q <= disp_sec_ones_d;
            disp_sec_tens_q <= disp_sec_tens_d;
            disp_min_ones_q <= disp_min_ones_d;
            disp_min_tens_q <= disp_min_tens_d;
        end
    end

    assign sw.lap_active    = lap_active_q;
    assign sw.disp_sec_ones = disp_sec_ones_q;
    assign sw.disp_sec_tens = disp_sec_tens_q;
    assign sw.disp_min_ones = disp_min_ones_q;
    assign sw.disp_min_tens = disp_min_tens_q;

`else

    logic lap_unused;

    assign lap_unused       = sw.btn_lap;
    assign sw.lap_active    = 1'b0;
    assign sw.disp_sec_ones = sec_ones_q;
    assign sw.disp_sec_tens = sec_tens_q;
    assign sw.disp_min_ones = min_ones_q;
    assign sw.disp_min_tens = min_tens_q;

`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios followed by randomized button/tick traffic,
// all checked cycle by cycle against a model that tracks elapsed seconds as a plain integer.
module tb_stopwatch_ctrl;

    localparam int MAX_MIN_TENS = 5;
    localparam int LIMIT_SECS   = (MAX_MIN_TENS + 1) * 600;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} model_mode_e;

    logic clk;
    logic resetn;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.MAX_MIN_TENS(MAX_MIN_TENS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw     (sw_if)
    );

    int num_compared;
    int num_mismatched;

    model_mode_e m_mode;
    int          m_secs;
    int          m_frozen;
    bit          m_ovf;
    bit          m_lap;
    bit          m_sub_clear;

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Convert elapsed seconds to packed BCD {min_tens, min_ones, sec_tens, sec_ones}
    function automatic logic [15:0] secsToBcd(input int secs);
        int mins;
        int s;
        mins = secs / 60;
        s    = secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] dispObserved();
        return {sw_if.disp_min_tens, sw_if.disp_min_ones, sw_if.disp_sec_tens, sw_if.disp_sec_ones};
    endfunction

    task automatic modelReset();
        m_mode      = M_IDLE;
        m_secs      = 0;
        m_frozen    = 0;
        m_ovf       = 1'b0;
        m_lap       = 1'b0;
        m_sub_clear = 1'b0;
    endtask

    // One clock of stopwatch behaviour: clear beats start/stop beats lap
    task automatic modelStep(input bit ss, input bit clr, input bit lap, input bit tick);
        model_mode_e old_mode;
        old_mode    = m_mode;
        m_sub_clear = clr;
        if (clr) begin
            m_mode   = M_IDLE;
            m_secs   = 0;
            m_ovf    = 1'b0;
            m_lap    = 1'b0;
            m_frozen = 0;
        end else begin
            if (tick && old_mode == M_RUN) begin
                m_secs = m_secs + 1;
                if (m_secs == LIMIT_SECS) begin
                    m_secs = 0;
                    m_ovf  = 1'b1;
                end
            end
            if (ss) begin
                m_mode = (old_mode == M_RUN) ? M_PAUSE : M_RUN;
            end else if (lap) begin
`ifdef STOPWATCH_LAP_EN
                if (old_mode == M_RUN) begin
                    if (m_lap) begin
                        m_lap = 1'b0;
                    end else begin
                        m_lap    = 1'b1;
                        m_frozen = m_secs;
                    end
                end else if (old_mode == M_PAUSE) begin
                    m_lap = 1'b0;
                end
`endif
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".running"},   32'(sw_if.running),    32'(m_mode == M_RUN));
        checkOutput({tag, ".count_en"},  32'(sw_if.count_en),   32'(m_mode == M_RUN));
        checkOutput({tag, ".sub_clear"}, 32'(sw_if.sub_clear),  32'(m_sub_clear));
        checkOutput({tag, ".ovf"},       32'(sw_if.ovf),        32'(m_ovf));
        checkOutput({tag, ".lap"},       32'(sw_if.lap_active), 32'(m_lap));
        checkOutput({tag, ".disp"},      32'(dispObserved()),   32'(secsToBcd(m_lap ? m_frozen : m_secs)));
    endtask

    // Drive one cycle of inputs, advance the model, then check just after the edge
    task automatic applyStimulus(input bit ss, input bit clr, input bit lap, input bit tick);
        @(negedge clk);
        sw_if.btn_start_stop = ss;
        sw_if.btn_clear      = clr;
        sw_if.btn_lap        = lap;
        sw_if.tick_in        = tick;
        modelStep(ss, clr, lap, tick);
        @(posedge clk);
        #1;
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        sw_if.btn_lap        = 1'b0;
        sw_if.tick_in        = 1'b0;
        checkAll("step");
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        resetn               = 1'b0;
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        sw_if.btn_lap        = 1'b0;
        sw_if.tick_in        = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset_disp", 32'(dispObserved()), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Ticks before any start are ignored
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Start then 75 ticks -> 01:15
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_count_en", 32'(sw_if.count_en), 32'd1);
        repeat (75) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("disp_0115", 32'(dispObserved()), 32'h0115);

        // Stop coincident with 4th tick counts that tick; later ticks ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("stop_tick_disp", 32'(dispObserved()), 32'h0004);
        checkOutput("stop_running", 32'(sw_if.running), 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pause_hold_disp", 32'(dispObserved()), 32'h0004);

        // Resume from PAUSE, then clear; preload to MAX:59 and wrap
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (LIMIT_SECS - 1) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("preload_max", 32'(dispObserved()), 32'h5959);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_disp", 32'(dispObserved()), 32'h0000);
        checkOutput("wrap_ovf", 32'(sw_if.ovf), 32'd1);
        checkOutput("wrap_running", 32'(sw_if.running), 32'd1);
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_sticky", 32'(sw_if.ovf), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("clear_ovf", 32'(sw_if.ovf), 32'd0);
        checkOutput("clear_sub_pulse", 32'(sw_if.sub_clear), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_sub_once", 32'(sw_if.sub_clear), 32'd0);

        // Clear + start/stop + tick together from RUN at 00:10
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_ss_disp", 32'(dispObserved()), 32'h0000);
        checkOutput("clr_ss_running", 32'(sw_if.running), 32'd0);

        // Lap freeze and release (ignored when the feature is not built)
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
        checkOutput("lap_frozen", 32'(dispObserved()), 32'h0010);
        checkOutput("lap_active", 32'(sw_if.lap_active), 32'd1);
`else
        checkOutput("lap_ignored", 32'(dispObserved()), 32'h0015);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("lap_release", 32'(dispObserved()), 32'h0015);
        checkOutput("lap_inactive", 32'(sw_if.lap_active), 32'd0);

        // Async reset mid-RUN at 02:30
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (150) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset_disp", 32'(dispObserved()), 32'h0230);
        #2;
        resetn = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_reset_disp", 32'(dispObserved()), 32'h0000);

        // Randomized buttons and ticks
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 16) == 0, ($urandom % 60) == 0,
                          ($urandom % 10) == 0, ($urandom % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
